// File: rtl/node_pkg.sv
// rtl/node_pkg.sv - shared node width, start node, sequencer states and direction codes
package node_pkg;

    localparam int NODE_W = 8;
    localparam logic [NODE_W-1:0] START_NODE = 8'd0;
    localparam int NODE_COUNT = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef enum logic [3:0] {
        LEFT      = 4'd0,
        RIGHT     = 4'd1,
        FORWARD   = 4'd2,
        REVERSE   = 4'd3,
        STOP      = 4'd4,
        F_LEFT0   = 4'd5,
        F_LEFT1   = 4'd6,
        F_FORWARD = 4'd7,
        F_RIGHT0  = 4'd8,
        F_RIGHT1  = 4'd9
    } dir_t;

endpackage

// File: rtl/path_sequencer_if.sv
// rtl/path_sequencer_if.sv - planner/line-follower handshake and node-triple bus
interface path_sequencer_if
    import node_pkg::*;
#(
    parameter int DEPTH = 32
) ();
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [NODE_W-1:0] wr_node;
    logic              wr_ready;
    logic              start;
    logic              node_detect;
    logic [NODE_W-1:0] p_node;
    logic [NODE_W-1:0] c_node;
    logic [NODE_W-1:0] n_node;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [LEN_W-1:0]  path_len;

    modport master (
        output wr_en, wr_node, start, node_detect,
        input  wr_ready, p_node, c_node, n_node, busy, done, overflow, path_len
    );

    modport slave (
        input  wr_en, wr_node, start, node_detect,
        output wr_ready, p_node, c_node, n_node, busy, done, overflow, path_len
    );
endinterface

// File: rtl/path_buffer.sv
// rtl/path_buffer.sv - path entry register array, synchronous write, combinational read
module path_buffer #(
    parameter int DEPTH = 32,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];

    // Contents need no reset: path_len gates which entries are meaningful.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/path_sequencer.sv
// rtl/path_sequencer.sv - steps the (prev, current, next) node triple on arrivals; optional ARRIVE_HOLDOFF_EN
module path_sequencer
    import node_pkg::*;
#(
    parameter int DEPTH = 32
`ifdef ARRIVE_HOLDOFF_EN
    , parameter int HOLDOFF = 50000
`endif
) (
    input logic           clock,
    input logic           reset,
    path_sequencer_if.slave bus
);
    localparam int LEN_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);

    seq_state_t        state;
    logic [LEN_W-1:0]  path_len, rd_ptr;
    logic [NODE_W-1:0] p_q, c_q, n_q, rd_data;
    logic              det_q, busy_q, done_q, ovf_q, ready_q;
    logic              wr_full, wr_ok, go, rising, arrival;
    logic [AW-1:0]     rd_addr;

    assign wr_full = (path_len == LEN_W'(DEPTH));
    assign wr_ok   = bus.wr_en && (state == IDLE) && !wr_full;
    assign go      = bus.start && (state == IDLE) && (wr_ok || (path_len != '0));
    assign rising  = bus.node_detect && !det_q;
    assign rd_addr = (state == RUN) ? rd_ptr[AW-1:0] : '0;

`ifdef ARRIVE_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF + 1);
    logic [HW-1:0] hold_cnt;

    assign arrival = (state == RUN) && rising && (hold_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 hold_cnt <= '0;
        else if (go)               hold_cnt <= '0;
        else if (arrival)          hold_cnt <= HW'(HOLDOFF);
        else if (hold_cnt != '0)   hold_cnt <= hold_cnt - 1'b1;
    end
`else
    assign arrival = (state == RUN) && rising;
`endif

    path_buffer #(.DEPTH(DEPTH), .W(NODE_W)) u_buf (
        .clock   (clock),
        .wr_en   (wr_ok),
        .wr_addr (path_len[AW-1:0]),
        .wr_data (bus.wr_node),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            path_len <= '0;
            rd_ptr   <= '0;
            p_q      <= START_NODE;
            c_q      <= START_NODE;
            n_q      <= START_NODE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            det_q    <= 1'b0;
        end else begin
            det_q  <= bus.node_detect;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok)                    path_len <= path_len + 1'b1;
                    else if (bus.wr_en && wr_full) ovf_q   <= 1'b1;
                    if (go) begin
                        state   <= RUN;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        p_q     <= c_q;
                        // Empty buffer means entry 0 is being written this very cycle.
                        n_q     <= (path_len == '0) ? bus.wr_node : rd_data;
                        rd_ptr  <= LEN_W'(1);
                    end
                end
                RUN: begin
                    if (arrival) begin
                        p_q <= c_q;
                        c_q <= n_q;
                        if (rd_ptr < path_len) begin
                            n_q    <= rd_data;
                            rd_ptr <= rd_ptr + 1'b1;
                        end else begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    path_len <= '0;
                    rd_ptr   <= '0;
                    ready_q  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p_node   = p_q;
    assign bus.c_node   = c_q;
    assign bus.n_node   = n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.wr_ready = ready_q;
    assign bus.path_len = path_len;
endmodule

// File: tb/tb_path_sequencer.sv
// tb/tb_path_sequencer.sv - self-checking bench for path_sequencer
module tb_path_sequencer;
    import node_pkg::*;

    localparam int DEPTH   = 32;
    localparam int HOLDOFF = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    path_sequencer_if #(.DEPTH(DEPTH)) bus ();

    path_sequencer #(
        .DEPTH(DEPTH)
`ifdef ARRIVE_HOLDOFF_EN
        , .HOLDOFF(HOLDOFF)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: the loaded path as a queue plus traversal index.
    int  q[$];
    int  m_p, m_c, m_n, m_k, cyc, last_acc;
    bit  m_run, m_donest, m_done_out, m_ovf, m_prev;

    typedef struct {
        bit we; int wn; bit st; bit dt;
        int ep; int ec; int en; bit edone; bit ebusy; int elen;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_p = START_NODE; m_c = START_NODE; m_n = START_NODE; m_k = 0;
        m_run = 0; m_donest = 0; m_done_out = 0; m_ovf = 0; m_prev = 0;
        cyc = 0; last_acc = -1000000;
    endtask

    task automatic model_step(input bit we, input int wn, input bit st, input bit dt);
        bit arrive;
        arrive = m_run && dt && !m_prev;
`ifdef ARRIVE_HOLDOFF_EN
        if (cyc - last_acc <= HOLDOFF) arrive = 0;
`endif
        m_prev = dt;
        m_done_out = 0;
        if (m_donest) begin
            q.delete();
            m_donest = 0;
        end else if (!m_run) begin
            if (we) begin
                if (q.size() < DEPTH) q.push_back(wn & 255);
                else m_ovf = 1;
            end
            if (st && q.size() > 0) begin
                m_run = 1; m_k = 0; m_p = m_c; m_n = q[0];
                last_acc = -1000000;
            end
        end else if (arrive) begin
            last_acc = cyc;
            m_p = m_c; m_c = m_n; m_k++;
            if (m_k < q.size()) m_n = q[m_k];
            else begin
                m_done_out = 1; m_run = 0; m_donest = 1;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("p_node",   bus.p_node,   m_p);
        chk("c_node",   bus.c_node,   m_c);
        chk("n_node",   bus.n_node,   m_n);
        chk("busy",     bus.busy,     m_run);
        chk("done",     bus.done,     m_done_out);
        chk("overflow", bus.overflow, m_ovf);
        chk("wr_ready", bus.wr_ready, !m_run && !m_donest);
        chk("path_len", bus.path_len, q.size());
    endtask

    task automatic tick(input bit we, input int wn, input bit st, input bit dt);
        bus.wr_en = we; bus.wr_node = wn[7:0]; bus.start = st; bus.node_detect = dt;
        @(posedge clock);
        model_step(we, wn, st, dt);
        #1;
        check_all();
    endtask

    initial begin
        tv[0] = '{1, 2, 0, 0,  0,  0,  0, 0, 0, 1};
        tv[1] = '{1, 8, 0, 0,  0,  0,  0, 0, 0, 2};
        tv[2] = '{1, 12, 0, 0, 0,  0,  0, 0, 0, 3};
        tv[3] = '{0, 0, 1, 0,  0,  0,  2, 0, 1, 3};
        tv[4] = '{0, 0, 0, 1,  0,  2,  8, 0, 1, 3};
        tv[5] = '{0, 0, 0, 0,  0,  2,  8, 0, 1, 3};
        tv[6] = '{0, 0, 0, 1,  2,  8, 12, 0, 1, 3};
        tv[7] = '{0, 0, 0, 0,  2,  8, 12, 0, 1, 3};
        tv[8] = '{0, 0, 0, 1,  8, 12, 12, 1, 0, 3};
        tv[9] = '{0, 0, 0, 0,  8, 12, 12, 0, 0, 0};

        bus.wr_en = 0; bus.wr_node = '0; bus.start = 0; bus.node_detect = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_all();

        // Basic three-node path.
        for (int i = 0; i < 10; i++) begin
            tick(tv[i].we, tv[i].wn, tv[i].st, tv[i].dt);
            chk($sformatf("t1_p[%0d]", i),    bus.p_node,   tv[i].ep);
            chk($sformatf("t1_c[%0d]", i),    bus.c_node,   tv[i].ec);
            chk($sformatf("t1_n[%0d]", i),    bus.n_node,   tv[i].en);
            chk($sformatf("t1_done[%0d]", i), bus.done,     tv[i].edone);
            chk($sformatf("t1_busy[%0d]", i), bus.busy,     tv[i].ebusy);
            chk($sformatf("t1_len[%0d]", i),  bus.path_len, tv[i].elen);
        end

        // Overfill: 33rd value must never surface.
        for (int i = 0; i < 33; i++) tick(1, 100 + i, 0, 0);
        chk("t2_len", bus.path_len, 32);
        chk("t2_ovf", bus.overflow, 1);
        tick(0, 0, 1, 0);
        chk("t2_first", bus.n_node, 100);
        for (int i = 0; i < 32; i++) begin
            tick(0, 0, 0, 1);
            chk("t2_no33", bus.n_node == 8'd132, 0);
            tick(0, 0, 0, 0);
        end
        chk("t2_ovf_sticky", bus.overflow, 1);
        chk("t2_idle_c", bus.c_node, 131);

        // node_detect held high across start; writes dropped in RUN.
        tick(1, 5, 0, 0);
        tick(1, 6, 0, 1);
        tick(0, 0, 1, 1);
        chk("t3_start_p", bus.p_node, 131);
        chk("t3_start_n", bus.n_node, 5);
        repeat (3) tick(0, 0, 0, 1);
        chk("t3_nostep", bus.c_node, 131);
        tick(1, 77, 0, 1);
        chk("t3_len", bus.path_len, 2);
        chk("t3_ready", bus.wr_ready, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("t3_step", bus.c_node, 5);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("t3_done", bus.done, 1);
        tick(0, 0, 0, 0);

        // Empty start ignored; write+start same cycle.
        tick(0, 0, 1, 0);
        chk("t4_busy", bus.busy, 0);
        chk("t4_c", bus.c_node, 6);
        chk("t4_n", bus.n_node, 6);
        tick(1, 1, 1, 0);
        chk("t4_run", bus.busy, 1);
        chk("t4_n1", bus.n_node, 1);
        tick(0, 0, 0, 1);
        chk("t4_single_done", bus.done, 1);
        tick(0, 0, 0, 0);

        // Close edges vs holdoff.
        tick(1, 20, 0, 0); tick(1, 21, 0, 0); tick(1, 22, 1, 0);
        tick(0, 0, 0, 1);
        chk("t5_first", bus.c_node, 20);
        repeat (4) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
`ifdef ARRIVE_HOLDOFF_EN
        chk("t5_close", bus.c_node, 20);
`else
        chk("t5_close", bus.c_node, 21);
`endif
        repeat (6) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
`ifdef ARRIVE_HOLDOFF_EN
        chk("t5_far", bus.c_node, 21);
`else
        chk("t5_far", bus.c_node, 22);
`endif
        repeat (12) tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        repeat (2) tick(0, 0, 0, 0);
        chk("t5_end_c", bus.c_node, 22);

        // Asynchronous reset mid-RUN.
        tick(1, 40, 0, 0); tick(1, 41, 0, 0); tick(1, 42, 1, 0);
        tick(0, 0, 0, 1);
        chk("t6_step", bus.c_node, 40);
        tick(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("t6_p", bus.p_node, 0);
        chk("t6_c", bus.c_node, 0);
        chk("t6_n", bus.n_node, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_len", bus.path_len, 0);
        chk("t6_ready", bus.wr_ready, 1);
        chk("t6_ovf", bus.overflow, 0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        tick(1, 7, 1, 0);
        tick(0, 0, 0, 1);
        chk("t6_reload_c", bus.c_node, 7);
        chk("t6_reload_done", bus.done, 1);
        tick(0, 0, 0, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 9) < 3, $urandom_range(0, 255),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 4) < 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
